fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Parametrised instruction-fetch front end: PC register, PC+step adder, instruction-memory handshake and IF/ID pipeline register.
- Adds stall, flush, branch redirect, wait-state memory support, a boot state and a saturating bubble counter.
- Sits between the hazard/branch logic and the decode stage; the IF/ID bundle feeds ID.

Parameters:
- PC_W, 16: PC/address width.
- INSTR_W, 16: instruction width.
- PC_STEP, 2: byte increment per instruction; power of two.
- RESET_PC, 0: PC value after reset.
- NOP_INSTR, 0: instruction loaded on a bubble.
- CNT_W, 16: bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and IF/ID (from the hazard unit).
- flush  in  1  kill IF/ID contents and the in-flight fetch.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  PC_W  branch target.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address, always equal to pc.
- imem_ready  in  1  imem_rdata is valid for imem_addr this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- pc  out  PC_W  current PC.
- pc_plus  out  PC_W  pc+PC_STEP, combinational.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  PC_W  PC of the IF/ID instruction.
- ifid_bundle  out  PC_W+INSTR_W  {pc_plus_at_fetch, instr}; the upper field goes to ID.
- bubble_count  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC; ifid_valid=0; ifid_pc=0; ifid_bundle={0,NOP_INSTR}; bubble_count=0; state=BOOT; imem_req=0.
  - Asserting reset mid-fetch discards everything immediately.
- States:
  - BOOT: imem_req=0; moves to FETCH on the next edge. There is exactly one BOOT cycle after reset deasserts.
  - FETCH: imem_req=1; stays in FETCH until reset.
- Fetch fire: fire = FETCH & imem_ready & ~stall & ~flush & ~redirect_valid.
  - On the edge after fire: pc<=pc+PC_STEP (mod 2^PC_W, wraps silently); ifid_valid<=1; ifid_pc<=pc; ifid_bundle<={pc+PC_STEP, imem_rdata}.
  - Latency: instruction at address A with ready in cycle t appears on the IF/ID outputs in cycle t+1.
- Per-edge priority (highest first):
  - redirect_valid: pc<=redirect_pc with the low log2(PC_STEP) bits forced to 0; IF/ID<=bubble. Applies even when stall=1.
  - flush: IF/ID<=bubble; pc held; the in-flight fetch is discarded and re-issued next cycle.
  - stall: pc, IF/ID and counter held; imem_req stays 1 and the address stays stable.
  - FETCH & ~imem_ready: pc held; IF/ID<=bubble.
  - fire: normal advance as above.
  - BOOT: pc held; IF/ID<=bubble.
- Bubble: ifid_valid=0; ifid_pc=0; ifid_bundle={0,NOP_INSTR}. bubble_count increments on every bubble load and saturates at 2^CNT_W-1.
- redirect_valid and flush together: redirect semantics apply; one bubble, counted once.
- No combinational path from imem_ready, imem_rdata or stall to any IF/ID output; all IF/ID outputs are registered.

Decomposition:
- Shared package cpu_pkg: PC_W, INSTR_W, PC_STEP and NOP_INSTR defaults, plus fetch state encoding (BOOT=1'b0, FETCH=1'b1).
- One natural sub-module, ifid_reg: load/bubble/hold register for valid, pc and bundle.
- PC register, adder, FSM and counter stay in fetch_stage.

Test Plan:
- Reset 1 for 20 ns, then 0; imem_ready=1; rdata = address-tagged pattern (rdata=addr^16'hA000) -> one BOOT cycle with imem_req=0; then pc 0000,0002,0004 on consecutive cycles; ifid_bundle=0002_A000, then 0004_A002; ifid_valid=1 from the 3rd cycle.
- stall=1 for 3 cycles at pc=0006 -> pc, ifid_bundle and bubble_count unchanged; imem_addr=0006 throughout; resumes with 0008_A006 one cycle after stall drops.
- redirect_valid=1, redirect_pc=0x0101, with stall=1 -> next pc=0100; ifid_valid=0, bundle=0000_0000, bubble_count+1; next fetch gives 0102_A100.
- imem_ready=0 for 2 cycles at pc=0010 -> two bubbles (bubble_count+2); pc held at 0010; ready=1 -> ifid_bundle=0012_A010.
- PC wrap: redirect to FFFE, ready=1 -> ifid_bundle=0000_5FFE, pc=0000.
- Async reset asserted mid-cycle during a stall -> all outputs return to reset values before the next clk edge; BOOT repeats after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Default datapath widths and the fetch FSM state encoding.
package cpu_pkg;

   localparam int          PC_W_DEF      = 16;
   localparam int          INSTR_W_DEF   = 16;
   localparam int          PC_STEP_DEF   = 2;
   localparam int unsigned NOP_INSTR_DEF = 0;

   typedef enum logic {
      BOOT  = 1'b0,
      FETCH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
// Bubble takes precedence over load; with neither asserted the contents hold.
module ifid_reg
   import cpu_pkg::*;
#(
   parameter int          PC_W      = PC_W_DEF,
   parameter int          INSTR_W   = INSTR_W_DEF,
   parameter int unsigned NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_load,
   input  logic                    i_bubble,
   input  logic [PC_W-1:0]         i_pc,
   input  logic [PC_W+INSTR_W-1:0] i_bundle,
   output logic                    o_valid,
   output logic [PC_W-1:0]         o_pc,
   output logic [PC_W+INSTR_W-1:0] o_bundle
);

   localparam logic [PC_W+INSTR_W-1:0] BUBBLE =
      {{PC_W{1'b0}}, INSTR_W'(NOP_INSTR)};

   logic                    r_valid;
   logic [PC_W-1:0]         r_pc;
   logic [PC_W+INSTR_W-1:0] r_bundle;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_bundle <= BUBBLE;
      end else if (i_bubble) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_bundle <= BUBBLE;
      end else if (i_load) begin
         r_valid  <= 1'b1;
         r_pc     <= i_pc;
         r_bundle <= i_bundle;
      end
   end

   assign o_valid  = r_valid;
   assign o_pc     = r_pc;
   assign o_bundle = r_bundle;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, step adder, imem handshake,
// boot FSM, IF/ID register and a saturating bubble counter.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int          PC_W      = PC_W_DEF,
   parameter int          INSTR_W   = INSTR_W_DEF,
   parameter int          PC_STEP   = PC_STEP_DEF,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned NOP_INSTR = NOP_INSTR_DEF,
   parameter int          CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    redirect_valid,
   input  logic [PC_W-1:0]         redirect_pc,
   output logic                    imem_req,
   output logic [PC_W-1:0]         imem_addr,
   input  logic                    imem_ready,
   input  logic [INSTR_W-1:0]      imem_rdata,
   output logic [PC_W-1:0]         pc,
   output logic [PC_W-1:0]         pc_plus,
   output logic                    ifid_valid,
   output logic [PC_W-1:0]         ifid_pc,
   output logic [PC_W+INSTR_W-1:0] ifid_bundle,
   output logic [CNT_W-1:0]        bubble_count
);

   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(PC_STEP - 1);
   localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;

   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_pc_nxt;
   logic [PC_W-1:0]  w_pc_plus;
   logic [CNT_W-1:0] r_cnt;
   logic             w_fetch;
   logic             w_fire;
   logic             w_bubble;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= BOOT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fetch     = 1'b0;
      unique case (r_state)
         BOOT:  w_state_nxt = FETCH;
         FETCH: w_fetch     = 1'b1;
         default: w_state_nxt = BOOT;
      endcase
   end

   assign w_pc_plus = r_pc + STEP;

   // Redirect/flush win over stall; stall suppresses the other bubble sources
   assign w_fire   = w_fetch & imem_ready & ~stall & ~flush & ~redirect_valid;
   assign w_bubble = redirect_valid | flush |
                     (~stall & (~w_fetch | ~imem_ready));

   always_comb begin
      w_pc_nxt = r_pc;
      if (redirect_valid) w_pc_nxt = redirect_pc & ~ALIGN_MASK;
      else if (w_fire)    w_pc_nxt = w_pc_plus;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc  <= PC_W'(RESET_PC);
         r_cnt <= '0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_bubble && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   ifid_reg #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_fire),
      .i_bubble (w_bubble),
      .i_pc     (r_pc),
      .i_bundle ({w_pc_plus, imem_rdata}),
      .o_valid  (ifid_valid),
      .o_pc     (ifid_pc),
      .o_bundle (ifid_bundle)
   );

   assign imem_req     = w_fetch;
   assign imem_addr    = r_pc;
   assign pc           = r_pc;
   assign pc_plus      = w_pc_plus;
   assign bubble_count = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a reference model feeding
// an expectation queue that is checked after every clock edge.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush, redirect_valid;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic [15:0] pc, pc_plus;
   logic        ifid_valid;
   logic [15:0] ifid_pc;
   logic [31:0] ifid_bundle;
   logic [15:0] bubble_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        req;
      logic [15:0] pc;
      logic        v;
      logic [15:0] ipc;
      logic [31:0] bun;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];

   // model state
   logic        m_fetch;
   logic [15:0] m_pc;
   logic        m_v;
   logic [15:0] m_ipc;
   logic [31:0] m_bun;
   logic [15:0] m_cnt;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .pc             (pc),
      .pc_plus        (pc_plus),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_bundle    (ifid_bundle),
      .bubble_count   (bubble_count)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ 16'hA000;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fetch = 1'b0;
      m_pc    = 16'h0000;
      m_v     = 1'b0;
      m_ipc   = 16'h0000;
      m_bun   = 32'h0;
      m_cnt   = 16'h0;
   endtask

   task automatic model_bubble();
      m_v   = 1'b0;
      m_ipc = 16'h0;
      m_bun = 32'h0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
   endtask

   // one clock: drive, predict, push, edge, pop, compare
   task automatic step(input logic st, input logic fl, input logic rv,
                       input logic [15:0] rpc, input logic rdy);
      exp_t e;
      logic [15:0] nx;
      stall = st; flush = fl; redirect_valid = rv;
      redirect_pc = rpc; imem_ready = rdy;
      nx = m_pc + 16'd2;
      if (rv) begin
         m_pc = {rpc[15:1], 1'b0};
         model_bubble();
      end else if (fl) begin
         model_bubble();
      end else if (st) begin
         // hold
      end else if (!m_fetch || !rdy) begin
         model_bubble();
      end else begin
         m_v   = 1'b1;
         m_ipc = m_pc;
         m_bun = {nx, m_pc ^ 16'hA000};
         m_pc  = nx;
      end
      m_fetch = 1'b1;
      e = '{req: m_fetch, pc: m_pc, v: m_v, ipc: m_ipc,
            bun: m_bun, cnt: m_cnt};
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("req", 64'(imem_req), 64'(e.req));
      chk("pc", 64'(pc), 64'(e.pc));
      chk("addr", 64'(imem_addr), 64'(e.pc));
      chk("valid", 64'(ifid_valid), 64'(e.v));
      chk("ifid_pc", 64'(ifid_pc), 64'(e.ipc));
      chk("bundle", 64'(ifid_bundle), 64'(e.bun));
      chk("cnt", 64'(bubble_count), 64'(e.cnt));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, 64'(pc), 64'h0);
      chk({tag, "_req"}, 64'(imem_req), 64'h0);
      chk({tag, "_valid"}, 64'(ifid_valid), 64'h0);
      chk({tag, "_ipc"}, 64'(ifid_pc), 64'h0);
      chk({tag, "_bundle"}, 64'(ifid_bundle), 64'h0);
      chk({tag, "_cnt"}, 64'(bubble_count), 64'h0);
   endtask

   initial begin
      logic [15:0] c0;
      reset = 1'b1;
      stall = 0; flush = 0; redirect_valid = 0;
      redirect_pc = 16'h0; imem_ready = 1'b1;
      model_reset();
      #2;
      chk_reset_vals("rst");
      #18;
      reset = 1'b0;
      #1;
      chk("boot_req", 64'(imem_req), 64'h0);

      step(0, 0, 0, 16'h0, 1);
      chk("fetch0_pc", 64'(pc), 64'h0000);
      chk("fetch0_req", 64'(imem_req), 64'h1);
      step(0, 0, 0, 16'h0, 1);
      chk("b1", 64'(ifid_bundle), 64'h0002_A000);
      chk("v1", 64'(ifid_valid), 64'h1);
      step(0, 0, 0, 16'h0, 1);
      chk("b2", 64'(ifid_bundle), 64'h0004_A002);
      step(0, 0, 0, 16'h0, 1);
      chk("pc6", 64'(pc), 64'h0006);

      c0 = bubble_count;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 16'h0, 1);
         chk("stall_addr", 64'(imem_addr), 64'h0006);
         chk("stall_bun", 64'(ifid_bundle), 64'h0006_A004);
         chk("stall_cnt", 64'(bubble_count), 64'(c0));
      end
      step(0, 0, 0, 16'h0, 1);
      chk("resume", 64'(ifid_bundle), 64'h0008_A006);

      c0 = bubble_count;
      step(1, 0, 1, 16'h0101, 1);
      chk("redir_pc", 64'(pc), 64'h0100);
      chk("redir_v", 64'(ifid_valid), 64'h0);
      chk("redir_bun", 64'(ifid_bundle), 64'h0);
      chk("redir_cnt", 64'(bubble_count), 64'(c0 + 16'd1));
      step(0, 0, 0, 16'h0, 1);
      chk("redir_f", 64'(ifid_bundle), 64'h0102_A100);

      step(0, 0, 1, 16'h0010, 1);
      c0 = bubble_count;
      step(0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 0);
      chk("nrdy_cnt", 64'(bubble_count), 64'(c0 + 16'd2));
      chk("nrdy_pc", 64'(pc), 64'h0010);
      step(0, 0, 0, 16'h0, 1);
      chk("rdy_bun", 64'(ifid_bundle), 64'h0012_A010);

      step(0, 1, 0, 16'h0, 1);
      chk("flush_pc", 64'(pc), 64'h0012);
      step(1, 1, 0, 16'h0, 1);
      step(0, 0, 0, 16'h0, 1);
      chk("refetch", 64'(ifid_bundle), 64'h0014_A012);
      c0 = bubble_count;
      step(0, 1, 1, 16'h0040, 1);
      chk("rf_cnt", 64'(bubble_count), 64'(c0 + 16'd1));
      chk("rf_pc", 64'(pc), 64'h0040);

      step(0, 0, 1, 16'hFFFE, 1);
      step(0, 0, 0, 16'h0, 1);
      chk("wrap_bun", 64'(ifid_bundle), 64'h0000_5FFE);
      chk("wrap_pc", 64'(pc), 64'h0000);

      step(1, 0, 0, 16'h0, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("arst");
      @(posedge clk);
      #1;
      chk_reset_vals("arst_hold");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      chk("reboot_req", 64'(imem_req), 64'h0);
      step(0, 0, 0, 16'h0, 1);
      chk("reboot_pc", 64'(pc), 64'h0000);
      chk("reboot_cnt", 64'(bubble_count), 64'h1);
      step(0, 0, 0, 16'h0, 1);
      chk("reboot_bun", 64'(ifid_bundle), 64'h0002_A000);

      chk("q_empty", 64'(q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
